// File: rtl/button_events.sv
// Classifies a debounced button level into one-clock event pulses (press, release,
// click, long press, auto-repeat). All timing is counted in ticks of the shared sample strobe.
module button_events #(
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn,
  output logic held,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic long_p,
  output logic repeat_p
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  // Clamped so a disabled repeat (REPEAT_TICKS=0) still yields a legal constant.
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_nxt, release_nxt, click_nxt, long_nxt, repeat_nxt;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    click_nxt   = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;

    if (en) begin
      unique case (state)
        IDLE: begin
          if (btn) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
            press_nxt = 1'b1;
          end
        end
        PRESSED: begin
          if (!btn) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
            click_nxt   = 1'b1;
          end else if (cnt == LONG_LAST) begin
            state_nxt = LONG;
            cnt_nxt   = '0;
            long_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        LONG: begin
          if (!btn) begin
            state_nxt   = IDLE;
            release_nxt = 1'b1;
          end else if (REPEAT_TICKS != 0) begin
            if (cnt == REP_LAST) begin
              cnt_nxt    = '0;
              repeat_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      held      <= 1'b0;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      click_p   <= 1'b0;
      long_p    <= 1'b0;
      repeat_p  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      held      <= (state_nxt != IDLE);
      press_p   <= press_nxt;
      release_p <= release_nxt;
      click_p   <= click_nxt;
      long_p    <= long_nxt;
      repeat_p  <= repeat_nxt;
    end
  end

endmodule
